// File: rtl/rv32_pkg.sv
// rv32_pkg: shared arbiter state encoding and RV32I constants
package rv32_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one Avalon master between instruction fetch and data ports
module rv32_mem_arbiter
  import rv32_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = RV32I_NOP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] iaddress,
  input  logic        iread,
  output logic [31:0] ireaddata,
  output logic        iwaitrequest,
  input  logic [31:0] daddress,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  input  logic        dread,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        bus_timeout
);

  localparam int WDW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t     state, state_n;
  logic [WDW-1:0] wd;
  logic           pend, hold_rd, hold_wr;
  logic [31:0]    hold_addr, hold_wdata;
  logic [3:0]     hold_be;
  logic           sel_i, sel_d, gnt, dreq, live, use_hold, timeout;
  logic           cur_rd, cur_wr, mcomp, done, report;
  logic [31:0]    rdata;

  // Grant state register; reset drops any transfer without reporting it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else state <= state_n;
  end

  // Re-arbitrate from IDLE or on completion, favouring the port not just served
  always_comb begin
    state_n = state;
    if (!gnt || done)
      state_n = (state == ARB_GNT_D) ? (iread ? ARB_GNT_I : dreq ? ARB_GNT_D : ARB_IDLE)
                                     : (dreq ? ARB_GNT_D : iread ? ARB_GNT_I : ARB_IDLE);
  end

  // Master port forwarding, held command for cancelled requests, completion and watchdog
  always_comb begin
    sel_i        = state == ARB_GNT_I;
    sel_d        = state == ARB_GNT_D;
    gnt          = sel_i | sel_d;
    dreq         = dread | dwrite;
    live         = sel_i ? iread : sel_d & dreq;
    use_hold     = gnt & ~live & pend;
    timeout      = (TIMEOUT_CYCLES != 0) && gnt && (wd == WDW'(TIMEOUT_CYCLES));
    cur_wr       = sel_d & dwrite;
    cur_rd       = sel_i | (sel_d & ~dwrite);
    m_address    = live ? (sel_i ? iaddress : daddress) : use_hold ? hold_addr : '0;
    m_read       = ~timeout & (live ? cur_rd : use_hold & hold_rd);
    m_write      = ~timeout & (live ? cur_wr : use_hold & hold_wr);
    m_writedata  = live ? (cur_wr ? dwritedata : '0) : use_hold ? hold_wdata : '0;
    m_byteenable = live ? (cur_wr ? dbyteenable : 4'hf) : use_hold ? hold_be : '0;
    mcomp        = (m_read | m_write) & ~m_waitrequest;
    done         = gnt & (mcomp | timeout | ~(live | use_hold));
    report       = live & (mcomp | timeout);
    rdata        = timeout ? TIMEOUT_RDATA : m_readdata;
    iwaitrequest = ~(sel_i & report);
    dwaitrequest = ~(sel_d & report);
    ireaddata    = (sel_i & report) ? rdata : '0;
    dreaddata    = (sel_d & report) ? rdata : '0;
    bus_timeout  = timeout;
  end

  // Track an outstanding strobe, snapshot the live command, count stalled cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      wd         <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
      hold_rd    <= 1'b0;
      hold_wr    <= 1'b0;
    end else begin
      pend <= gnt & (m_read | m_write) & m_waitrequest;
      wd   <= (done | ~gnt) ? '0 : wd + WDW'(m_waitrequest & (m_read | m_write));
      if (live) begin
        hold_addr  <= m_address;
        hold_wdata <= m_writedata;
        hold_be    <= m_byteenable;
        hold_rd    <= cur_rd;
        hold_wr    <= cur_wr;
      end
    end
  end

  a_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(dread && dwrite));

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed checks of arbitration, alternation, writes, cancel, watchdog and reset
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0, reset_n;
  logic [31:0] iaddress, daddress, dwritedata, m_readdata;
  logic        iread, dwrite, dread, m_waitrequest;
  logic [3:0]  dbyteenable;
  logic [31:0] ireaddata, dreaddata, m_address, m_writedata;
  logic        iwaitrequest, dwaitrequest, m_read, m_write, bus_timeout;
  logic [3:0]  m_byteenable;
  int          vec = 0, err = 0, icnt, dcnt;

  rv32_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .iaddress(iaddress), .iread(iread), .ireaddata(ireaddata), .iwaitrequest(iwaitrequest),
    .daddress(daddress), .dwrite(dwrite), .dwritedata(dwritedata), .dbyteenable(dbyteenable),
    .dread(dread), .dreaddata(dreaddata), .dwaitrequest(dwaitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic quiet;
    iread = 0; dread = 0; dwrite = 0; m_waitrequest = 0;
    nxt; nxt; nxt;
  endtask

  initial begin
    reset_n = 0; iread = 0; dread = 0; dwrite = 0; m_waitrequest = 0;
    iaddress = 0; daddress = 0; dwritedata = 0; dbyteenable = 0; m_readdata = 0;
    smp;
    chk("rst_mread", m_read, 0);
    chk("rst_mwrite", m_write, 0);
    chk("rst_maddr", m_address, 0);
    chk("rst_iwait", iwaitrequest, 1);
    chk("rst_dwait", dwaitrequest, 1);
    chk("rst_tmo", bus_timeout, 0);
    nxt; nxt;
    reset_n = 1;
    nxt;
    // single fetch with three stalled cycles
    iread = 1; iaddress = 32'h100; m_waitrequest = 1;
    smp; chk("t1_c0_mread", m_read, 0); chk("t1_c0_iwait", iwaitrequest, 1);
    nxt; smp; chk("t1_c1_mread", m_read, 1); chk("t1_c1_addr", m_address, 32'h100);
    chk("t1_c1_be", m_byteenable, 4'hf); chk("t1_c1_iwait", iwaitrequest, 1);
    nxt; smp; chk("t1_c2_iwait", iwaitrequest, 1);
    nxt; smp; chk("t1_c3_iwait", iwaitrequest, 1); chk("t1_c3_rdata", ireaddata, 0);
    nxt; m_waitrequest = 0; m_readdata = 32'hA5A5A5A5;
    smp; chk("t1_c4_iwait", iwaitrequest, 0); chk("t1_c4_rdata", ireaddata, 32'hA5A5A5A5);
    nxt; quiet;
    // simultaneous requests: data first, then fetch with no bubble
    iread = 1; iaddress = 32'h104; dread = 1; daddress = 32'h300; m_readdata = 32'h11;
    smp; chk("t2_c0_mread", m_read, 0);
    nxt; smp; chk("t2_c1_addr", m_address, 32'h300); chk("t2_c1_dwait", dwaitrequest, 0);
    chk("t2_c1_drdata", dreaddata, 32'h11); chk("t2_c1_iwait", iwaitrequest, 1);
    nxt; dread = 0;
    smp; chk("t2_c2_addr", m_address, 32'h104); chk("t2_c2_iwait", iwaitrequest, 0);
    chk("t2_c2_irdata", ireaddata, 32'h11); chk("t2_c2_dwait", dwaitrequest, 1);
    chk("t2_c2_drdata", dreaddata, 0);
    nxt; quiet;
    // continuous contention alternates D,I,D,I
    iread = 1; dread = 1; icnt = 0; dcnt = 0;
    nxt;
    for (int k = 0; k < 20; k++) begin
      smp;
      chk("t3_dwait", dwaitrequest, (k % 2 == 0) ? 0 : 1);
      chk("t3_iwait", iwaitrequest, (k % 2 == 0) ? 1 : 0);
      if (!dwaitrequest) dcnt++;
      if (!iwaitrequest) icnt++;
      nxt;
    end
    chk("t3_dcnt", dcnt, 10);
    chk("t3_icnt", icnt, 10);
    quiet;
    // byte-enabled write, single completion
    dwrite = 1; daddress = 32'h200; dwritedata = 32'h12345678; dbyteenable = 4'b0011;
    smp; chk("t4_c0_mwrite", m_write, 0);
    nxt; smp; chk("t4_mwrite", m_write, 1); chk("t4_mread", m_read, 0);
    chk("t4_addr", m_address, 32'h200); chk("t4_wdata", m_writedata, 32'h12345678);
    chk("t4_be", m_byteenable, 4'b0011); chk("t4_dwait", dwaitrequest, 0);
    nxt; dwrite = 0;
    smp; chk("t4_once_mwrite", m_write, 0); chk("t4_once_dwait", dwaitrequest, 1);
    nxt; quiet;
    // watchdog on a stuck fetch
    iread = 1; iaddress = 32'h400; m_waitrequest = 1;
    nxt;
    for (int k = 1; k <= 8; k++) begin
      smp;
      chk("t5_wait_iwait", iwaitrequest, 1);
      chk("t5_wait_tmo", bus_timeout, 0);
      chk("t5_wait_mread", m_read, 1);
      nxt;
    end
    smp; chk("t5_iwait", iwaitrequest, 0); chk("t5_rdata", ireaddata, 32'h13);
    chk("t5_tmo", bus_timeout, 1); chk("t5_mread", m_read, 0);
    nxt; iread = 0; m_waitrequest = 0;
    smp; chk("t5_tmo_once", bus_timeout, 0);
    nxt; quiet;
    // cancelled fetch: strobe and address held, completion discarded
    iread = 1; iaddress = 32'h500; m_waitrequest = 1;
    nxt; smp; chk("cx_c1_mread", m_read, 1);
    nxt; iread = 0; iaddress = 32'h999;
    smp; chk("cx_c2_mread", m_read, 1); chk("cx_c2_addr", m_address, 32'h500);
    chk("cx_c2_iwait", iwaitrequest, 1);
    nxt; m_waitrequest = 0; m_readdata = 32'h77;
    smp; chk("cx_c3_mread", m_read, 1); chk("cx_c3_iwait", iwaitrequest, 1);
    chk("cx_c3_rdata", ireaddata, 0);
    nxt; smp; chk("cx_c4_mread", m_read, 0);
    nxt; quiet;
    // asynchronous reset during a stalled data read
    dread = 1; daddress = 32'h600; m_waitrequest = 1;
    nxt; smp; chk("t6_pre_mread", m_read, 1);
    #2 reset_n = 0;
    #1 chk("t6_rst_mread", m_read, 0); chk("t6_rst_mwrite", m_write, 0);
    chk("t6_rst_dwait", dwaitrequest, 1);
    nxt; dread = 0; m_waitrequest = 0; reset_n = 1;
    smp; chk("t6_rel_mread", m_read, 0);
    nxt; dread = 1; daddress = 32'h604;
    smp; chk("t6_idle_mread", m_read, 0);
    nxt; smp; chk("t6_gnt_mread", m_read, 1); chk("t6_gnt_addr", m_address, 32'h604);
    nxt; quiet;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
